// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scanner. Each digit gets a blanking gap and then a drive window.
// Digits are written to a shadow buffer and published to the active buffer only at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       wr_en_i,
  input  logic [1:0] wr_idx_i,
  input  logic [4:0] wr_data_i,
  input  logic       wr_dp_i,
  input  logic       commit_i,
  output logic       commit_pending_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_tick_o
);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_e;

  typedef struct packed {
    logic       blank;
    logic [3:0] hex;
    logic       dp;
  } digit_t;

  localparam digit_t      DIGIT_BLANK = '{blank: 1'b1, hex: 4'h0, dp: 1'b0};
  localparam logic [19:0] BLANK_LAST  = 20'(BLANK_CYCLES - 1);
  localparam logic [19:0] DWELL_LAST  = 20'(DWELL_CYCLES - 1);
  localparam logic [1:0]  IDX_LAST    = 2'(NUM_DIGITS - 1);
  localparam logic [3:0]  AN_OFF      = {4{ACTIVE_LOW}};
  localparam logic [6:0]  SEG_OFF     = {7{ACTIVE_LOW}};

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [19:0] cnt_q, cnt_d;
  logic        commit_pending_q, commit_pending_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_tick_q, frame_tick_d;
  digit_t      shadow_q [4];
  digit_t      active_q [4];

  logic        frame_end;
  logic        apply;
  logic        drive;
  logic        wr_ok;
  digit_t      sel;

  // High-true gfedcba pattern; the output polarity is applied afterwards.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 20'd1;
    frame_end = 1'b0;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        if (enable_i) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (!enable_i) begin
      state_d   = S_OFF;
      idx_d     = '0;
      cnt_d     = '0;
      frame_end = 1'b0;
    end

    // A commit sampled on the boundary edge itself stays pending for the next boundary.
    apply            = commit_pending_q && (frame_end || state_q == S_OFF);
    commit_pending_d = commit_i || (commit_pending_q && !apply);

    // Outputs are computed from the next state so the registers line up with the state.
    drive        = (state_d == S_DRIVE);
    sel          = active_q[idx_d];
    an_d         = (drive ? (4'b0001 << idx_d) : 4'b0000) ^ AN_OFF;
    seg_d        = ((drive && !sel.blank) ? hex_to_seg(sel.hex) : 7'h00) ^ SEG_OFF;
    dp_d         = (drive && sel.dp) ^ ACTIVE_LOW;
    frame_tick_d = drive && (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);

    wr_ok = ({30'b0, wr_idx_i} < NUM_DIGITS);
  end

  // NOTE: the digit buffers are reset because the display must come up blank, not with stale contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_OFF;
      idx_q            <= '0;
      cnt_q            <= '0;
      commit_pending_q <= 1'b0;
      an_q             <= AN_OFF;
      seg_q            <= SEG_OFF;
      dp_q             <= ACTIVE_LOW;
      frame_tick_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= DIGIT_BLANK;
        active_q[i] <= DIGIT_BLANK;
      end
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      commit_pending_q <= commit_pending_d;
      an_q             <= an_d;
      seg_q            <= seg_d;
      dp_q             <= dp_d;
      frame_tick_q     <= frame_tick_d;
      if (wr_en_i && wr_ok)
        shadow_q[wr_idx_i] <= '{blank: wr_data_i[4], hex: wr_data_i[3:0], dp: wr_dp_i};
      // NOTE: non-blocking update means a same-cycle write is not seen by this copy.
      if (apply)
        active_q <= shadow_q;
    end
  end

  assign commit_pending_o = commit_pending_q;
  assign an_o             = an_q;
  assign seg_o            = seg_q;
  assign dp_o             = dp_q;
  assign frame_tick_o     = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboarded bench for seg7_scan_ctrl: expected drive windows are queued by the stimulus
// and checked by a monitor that watches the anode bus.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0, wr_en_a = 1'b0, wr_dp_a = 1'b0, commit_a = 1'b0;
  logic [1:0] wr_idx_a = '0;
  logic [4:0] wr_data_a = '0;
  logic       pend_a, dp_a, tick_a;
  logic [3:0] an_a;
  logic [6:0] seg_a;

  logic       en_b = 1'b0, wr_en_b = 1'b0, wr_dp_b = 1'b0, commit_b = 1'b0;
  logic [1:0] wr_idx_b = '0;
  logic [4:0] wr_data_b = '0;
  logic       pend_b, dp_b, tick_b;
  logic [3:0] an_b;
  logic [6:0] seg_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
  } win_t;

  win_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en_a), .wr_en_i(wr_en_a), .wr_idx_i(wr_idx_a),
    .wr_data_i(wr_data_a), .wr_dp_i(wr_dp_a), .commit_i(commit_a), .commit_pending_o(pend_a),
    .an_o(an_a), .seg_o(seg_a), .dp_o(dp_a), .frame_tick_o(tick_a)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(3), .DWELL_CYCLES(1), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en_b), .wr_en_i(wr_en_b), .wr_idx_i(wr_idx_b),
    .wr_data_i(wr_data_b), .wr_dp_i(wr_dp_b), .commit_i(commit_b), .commit_pending_o(pend_b),
    .an_o(an_b), .seg_o(seg_b), .dp_o(dp_b), .frame_tick_o(tick_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected values are given high-true; unit A drives low-true.
  task automatic push_win(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int len);
    win_t w;
    w.an  = ~an;
    w.seg = ~seg;
    w.dp  = ~dp;
    w.len = len;
    exp_q.push_back(w);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dps);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) push_win(4'(1 << i), s[i], dps[i], 4);
  endtask

  task automatic wr_a(input logic [1:0] idx, input logic [4:0] data, input logic dp);
    wr_en_a = 1'b1; wr_idx_a = idx; wr_data_a = data; wr_dp_a = dp;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic commit_pulse_a();
    commit_a = 1'b1;
    @(negedge clk);
    commit_a = 1'b0;
  endtask

  task automatic wait_tick(input string name, output int at);
    bit seen = 1'b0;
    at = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (tick_a) begin
        seen = 1'b1;
        at   = cyc_cnt;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: frame_tick not seen within 60 cycles", name);
    end
  endtask

  task automatic check_off_a(input string name);
    check({name, "_an"}, an_a, 4'hF);
    check({name, "_seg"}, seg_a, 7'h7F);
    check({name, "_dp"}, dp_a, 1'b1);
  endtask

  // Monitor: collects each drive window on unit A and compares it with the queue.
  initial begin
    logic [3:0] c_an;
    logic [6:0] c_seg;
    logic       c_dp;
    logic       c_bad;
    int         c_len;
    win_t       e;
    c_len = 0;
    c_bad = 1'b0;
    c_an = '0; c_seg = '0; c_dp = 1'b0;
    forever begin
      @(negedge clk);
      if (an_a != 4'hF) begin
        if (c_len == 0) begin
          c_an = an_a; c_seg = seg_a; c_dp = dp_a; c_bad = 1'b0;
        end else if (an_a != c_an || seg_a != c_seg || dp_a != c_dp) begin
          c_bad = 1'b1;
        end
        c_len++;
      end else if (c_len != 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL win_unexpected: an=%b seg=%h dp=%b len=%0d, expected no window", c_an, c_seg, c_dp, c_len);
        end else begin
          e = exp_q.pop_front();
          check("win_an", c_an, e.an);
          check("win_seg", c_seg, e.seg);
          check("win_dp", c_dp, e.dp);
          check("win_len", c_len, e.len);
          check("win_stable", c_bad, 1'b0);
        end
        c_len = 0;
      end
      if (tick_a) check("tick_align", {an_a, 8'(c_len)}, {4'b0111, 8'd4});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, tx;
    logic [12:0] b_exp [8];

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, enable low: both units stay dark.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_off_a("rst_idle");
    end
    check("rst_pending", pend_a, 1'b0);
    check("rst_tick", tick_a, 1'b0);
    check("rst_b_out", {an_b, seg_b, dp_b, tick_b, pend_b}, 14'h0);

    // Unit B: 3 digits, high-true, minimal timing; idx3 write must be ignored.
    wr_en_b = 1'b1; wr_idx_b = 2'd0; wr_data_b = 5'h05; wr_dp_b = 1'b1;
    @(negedge clk);
    wr_idx_b = 2'd3; wr_data_b = 5'h08;
    @(negedge clk);
    wr_en_b = 1'b0; commit_b = 1'b1;
    @(negedge clk);
    commit_b = 1'b0;
    check("b_pending_set", pend_b, 1'b1);
    @(negedge clk);
    check("b_pending_off_apply", pend_b, 1'b0);
    b_exp[0] = '0;
    b_exp[1] = {4'h1, 7'h6D, 1'b1, 1'b0};
    b_exp[2] = '0;
    b_exp[3] = {4'h2, 7'h00, 1'b0, 1'b0};
    b_exp[4] = '0;
    b_exp[5] = {4'h4, 7'h00, 1'b0, 1'b1};
    b_exp[6] = '0;
    b_exp[7] = {4'h1, 7'h6D, 1'b1, 1'b0};
    en_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b_slot%0d", i), {an_b, seg_b, dp_b, tick_b}, b_exp[i]);
    end
    en_b = 1'b0;
    @(negedge clk);
    check("b_disable_off", {an_b, seg_b, dp_b}, 12'h0);

    // Unit A frame 1: blank digits, 2 blank cycles before digit 0.
    push_frame(7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
    en_a = 1'b1;
    @(negedge clk); check("en_blank0", an_a, 4'hF);
    @(negedge clk); check("en_blank1", an_a, 4'hF);
    @(negedge clk); check("en_first_an", an_a, 4'b1110);
    check("en_first_seg", seg_a, 7'h7F);
    wait_tick("tick_f1", t1);

    // Frame 2: load 1,2,3,4 and commit mid-frame; display stays blank.
    push_frame(7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
    wr_a(2'd0, 5'h01, 1'b0);
    wr_a(2'd1, 5'h02, 1'b0);
    wr_a(2'd2, 5'h03, 1'b0);
    wr_a(2'd3, 5'h04, 1'b0);
    repeat (2) @(negedge clk);
    commit_pulse_a();
    check("commit_pending_set", pend_a, 1'b1);
    wait_tick("tick_f2", t2);
    check("frame_period", t2 - t1, 24);
    check("pending_at_tick", pend_a, 1'b1);
    push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0000);
    @(negedge clk);
    check("pending_cleared", pend_a, 1'b0);

    // Frame 3: digit 2 becomes blank with dp set.
    wr_a(2'd2, 5'h10, 1'b1);
    commit_pulse_a();
    wait_tick("tick_f3", tx);
    push_frame(7'h06, 7'h5B, 7'h00, 7'h66, 4'b0100);
    @(negedge clk);
    check("blank_commit_cleared", pend_a, 1'b0);

    // Frame 4: commit on the tick cycle is held to the next boundary.
    wr_a(2'd1, 5'h0A, 1'b0);
    wait_tick("tick_f4", tx);
    commit_a = 1'b1;
    push_frame(7'h06, 7'h5B, 7'h00, 7'h66, 4'b0100);
    @(negedge clk);
    commit_a = 1'b0;
    check("tick_commit_held", pend_a, 1'b1);

    // Frame 5: write on the apply cycle lands only in shadow.
    wait_tick("tick_f5", tx);
    check("tick_commit_pending", pend_a, 1'b1);
    wr_en_a = 1'b1; wr_idx_a = 2'd0; wr_data_a = 5'h0F; wr_dp_a = 1'b0;
    push_frame(7'h06, 7'h77, 7'h00, 7'h66, 4'b0100);
    @(negedge clk);
    wr_en_a = 1'b0;
    check("race_applied", pend_a, 1'b0);

    // Frame 6: second commit publishes the raced write; frame 7 is cut in digit 2.
    commit_pulse_a();
    wait_tick("tick_f6", tx);
    push_win(4'b0001, 7'h71, 1'b0, 4);
    push_win(4'b0010, 7'h77, 1'b0, 4);
    push_win(4'b0100, 7'h00, 1'b1, 2);
    repeat (16) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    check_off_a("drop");
    check("drop_tick", tick_a, 1'b0);
    wr_a(2'd3, 5'h08, 1'b0);
    commit_pulse_a();
    check("off_pending_set", pend_a, 1'b1);
    @(negedge clk);
    check("off_pending_applied", pend_a, 1'b0);

    // Re-enable restarts at digit 0 blanking with the new contents.
    push_frame(7'h71, 7'h77, 7'h00, 7'h7F, 4'b0100);
    en_a = 1'b1;
    @(negedge clk); check("reen_blank0", an_a, 4'hF);
    @(negedge clk); check("reen_blank1", an_a, 4'hF);
    @(negedge clk); check("reen_first_an", an_a, 4'b1110);
    wait_tick("tick_f8", tx);

    // Reset during digit 0 drive with a commit pending.
    commit_a = 1'b1;
    push_win(4'b0001, 7'h71, 1'b0, 1);
    @(negedge clk);
    commit_a = 1'b0;
    check("prerst_pending", pend_a, 1'b1);
    repeat (2) @(negedge clk);
    check("prerst_driving", an_a, 4'b1110);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_off_a("midrst");
    check("midrst_pending", pend_a, 1'b0);
    check("midrst_tick", tick_a, 1'b0);
    push_frame(7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
    wait_tick("tick_postrst", tx);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    en_a = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexes one shared 7-segment bus (seg/dp) across NUM_DIGITS anodes.
- Each digit gets a blanking gap, then a drive window.
- Digit contents arrive from the UART command path into a shadow buffer. They become visible atomically at a frame boundary after a commit pulse.
- Sits between the UART command decoder and the board's seg/an pins, and replaces the free-running select toggle.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal 2..4.
- DWELL_CYCLES, 100000, clk cycles each digit is driven (1 ms at 100 MHz); legal 1..2^20-1.
- BLANK_CYCLES, 1000, clk cycles all anodes off before each digit (anti-ghosting); legal 1..2^20-1.
- ACTIVE_LOW, 1, 1: an/seg/dp are driven low-true; 0: high-true.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  scan enable; 0 forces all outputs off.
- wr_en  in  1  write strobe to the shadow buffer.
- wr_idx  in  2  shadow digit index.
- wr_data  in  5  bit4 = blank flag, [3:0] = hex value.
- wr_dp  in  1  decimal point for the written digit.
- commit  in  1  one-cycle request to publish shadow to active.
- commit_pending  out  1  commit requested but not yet applied.
- an  out  4  anode enables; unused bits are always inactive.
- seg  out  7  segments; seg[0]=a ... seg[6]=g.
- dp  out  1  decimal point.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=S_OFF, idx=0, counter=0.
  - Shadow and active entries all = blank with dp=0.
  - commit_pending=0, frame_tick=0.
  - an, seg, dp all at the inactive level.
  - Reset mid-scan takes effect on the next edge; no partial digit completes.
- All outputs are registered. an/seg/dp change only on clk edges.
- S_OFF:
  - Outputs inactive.
  - If enable=1: go to S_BLANK with idx=0, counter=0.
- S_BLANK:
  - Outputs inactive.
  - Counter counts 0..BLANK_CYCLES-1, then go to S_DRIVE with counter=0.
  - Blanking therefore lasts exactly BLANK_CYCLES cycles.
- S_DRIVE:
  - an[idx] active, all other anodes inactive.
  - seg = decode(active[idx]); dp = active dp bit.
  - Lasts exactly DWELL_CYCLES cycles, then go to S_BLANK with counter=0.
  - If idx=NUM_DIGITS-1: idx wraps to 0, frame_tick=1 for that cycle, and the commit rule below applies. Otherwise idx+1.
- enable=0 in any state: next state S_OFF, idx=0, counter=0, outputs inactive. Shadow, active and commit_pending are retained.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles. The first frame after enable starts with digit 0's blanking.
- Decode:
  - Standard hex 0-F, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (high-true form).
  - Blank flag set: seg all off; dp still follows the stored dp bit.
  - ACTIVE_LOW=1 inverts an/seg/dp at the output register.
- Shadow write:
  - wr_en=1 stores {wr_data, wr_dp} into shadow[wr_idx] at the edge.
  - wr_idx >= NUM_DIGITS: write ignored.
  - Writes never alter the active buffer directly.
- Commit:
  - commit=1 sets commit_pending on the next edge.
  - A commit while already pending has no extra effect.
  - Application: active <= shadow (all digits in one edge) and commit_pending clears. This happens at the S_DRIVE to S_BLANK edge of the last digit (the frame_tick cycle), or on the next edge if the state is S_OFF.
  - commit asserted in the same cycle as the frame boundary is not applied at that boundary; it applies at the next boundary.
  - wr_en in the same cycle as application: active takes the pre-write shadow value; the write lands only in shadow.
- Counter is 20 bits with no overflow path; comparisons use parameter-1.

Test Plan:
- Reset/enable: NUM_DIGITS=4, DWELL=4, BLANK=2, ACTIVE_LOW=1. Hold rst, then release with enable=0 -> an=4'hF, seg=7'h7F, dp=1 indefinitely. Set enable=1 -> 2 blank cycles, then an=4'b1110 for 4 cycles; frame_tick every 24 cycles.
- Commit atomicity: write digits 0..3 = 1,2,3,4 (no blank), then pulse commit mid-frame. Display stays blank until the next frame_tick, then commit_pending falls. The following frame shows seg=~06,~5B,~4F,~66 on an=1110,1101,1011,0111.
- Blank and dp: write idx2 = blank flag with wr_dp=1, then commit -> during digit 2, seg=7'h7F and dp=0.
- Boundary races: commit on the frame_tick cycle -> not applied until the next boundary. wr_en to idx0 on the apply cycle -> active gets the old value; a second commit publishes the new one.
- Enable drop/ignored write: deassert enable mid-DRIVE of digit 2 -> outputs inactive next edge. Re-enable -> restarts at digit 0 blanking. A pending commit applies while in S_OFF. wr_idx=3 with NUM_DIGITS=3 -> ignored.
- Reset mid-scan: assert rst during S_DRIVE with commit_pending=1 -> all outputs inactive and commit_pending=0 after one edge; active buffer blank.
